// File: rtl/io_ram_pkg.sv
// Shared constants for the io_ram port A controller: geometry and grant encoding.
package io_ram_pkg;

  localparam int unsigned IO_RAM_AW = 12;
  localparam int unsigned IO_RAM_DW = 8;

  // Bit positions of the requesters inside the arbiter req/gnt vectors
  localparam int unsigned REQ_RX = 0;
  localparam int unsigned REQ_TX = 1;

  typedef enum logic {
    GNT_RX = 1'b0,
    GNT_TX = 1'b1
  } gnt_e;

endpackage

// File: rtl/io_ram_rr_arb.sv
// Two-requester round-robin arbiter; remembers the last winner to break ties.
module io_ram_rr_arb
  import io_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt_c,
  output gnt_e       last_gnt
);

  // On a tie the requester that did not win last time is served
  always_comb begin
    gnt_c = 2'b00;
    if (req == 2'b11) begin
      if (last_gnt == GNT_RX) gnt_c[REQ_TX] = 1'b1;
      else                    gnt_c[REQ_RX] = 1'b1;
    end else begin
      gnt_c = req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                 last_gnt <= GNT_TX;
    else if (gnt_c[REQ_TX])  last_gnt <= GNT_TX;
    else if (gnt_c[REQ_RX])  last_gnt <= GNT_RX;
  end

endmodule

// File: rtl/io_ram_ctrl.sv
// Port A controller for io_ram: circular byte FIFO between the UART receiver
// (writes) and transmitter (reads), one RAM access per cycle.
module io_ram_ctrl
  import io_ram_pkg::*;
#(
  parameter int unsigned AW = IO_RAM_AW,
  parameter int unsigned DW = IO_RAM_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          rx_valid,
  input  logic [DW-1:0] rx_data,
  output logic          rx_ready,
  output logic          tx_valid,
  output logic [DW-1:0] tx_data,
  input  logic          tx_ready,
  output logic          en_porta,
  output logic          wr_porta,
  output logic [AW-1:0] addra,
  output logic [DW-1:0] wr_dataa,
  input  logic [DW-1:0] rd_dataa,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wr_ptr, wr_ptr_d;
  logic [AW-1:0] rd_ptr, rd_ptr_d;
  logic [AW:0]   level_d;
  logic          tx_valid_d;
  logic [DW-1:0] tx_data_d;
  logic          rd_inflight, rd_inflight_d;
  logic          rd_req, wr_req;
  logic [1:0]    gnt;
  gnt_e          last_gnt;

  assign empty = (level == '0);
  assign full  = (level == DEPTH);

  // Requests are masked during reset so port A stays idle until released
  assign rd_req = ~rst & ~empty & ~tx_valid & ~rd_inflight & ~flush;
  assign wr_req = ~rst & rx_valid & ~full & ~flush;

  // Ready already accounts for losing a tie to the transmitter
  assign rx_ready = ~full & ~flush & ~(rd_req & (last_gnt == GNT_RX));

  io_ram_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      ({rd_req, wr_req}),
    .gnt_c    (gnt),
    .last_gnt (last_gnt)
  );

  assign en_porta = |gnt;
  assign wr_porta = gnt[REQ_RX];
  assign addra    = gnt[REQ_RX] ? wr_ptr : rd_ptr;
  assign wr_dataa = rx_data;

  always_comb begin
    wr_ptr_d      = wr_ptr;
    rd_ptr_d      = rd_ptr;
    level_d       = level;
    tx_valid_d    = tx_valid;
    tx_data_d     = tx_data;
    rd_inflight_d = 1'b0;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      tx_valid_d = 1'b0;
    end else begin
      if (gnt[REQ_RX]) begin
        wr_ptr_d = wr_ptr + AW'(1);
        level_d  = level + (AW+1)'(1);
      end
      if (gnt[REQ_TX]) begin
        rd_ptr_d      = rd_ptr + AW'(1);
        level_d       = level - (AW+1)'(1);
        rd_inflight_d = 1'b1;
      end
      // RAM data arrives one cycle after the read grant
      if (rd_inflight) begin
        tx_data_d  = rd_dataa;
        tx_valid_d = 1'b1;
      end else if (tx_valid && tx_ready) begin
        tx_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_d;
      rd_ptr      <= rd_ptr_d;
      level       <= level_d;
      tx_valid    <= tx_valid_d;
      tx_data     <= tx_data_d;
      rd_inflight <= rd_inflight_d;
    end
  end

endmodule

// File: tb/tb_io_ram_ctrl.sv
// Directed bench for io_ram_ctrl with a behavioural 4096x8 port A RAM.
module tb_io_ram_ctrl;
  import io_ram_pkg::*;

  localparam int unsigned AW = IO_RAM_AW;
  localparam int unsigned DW = IO_RAM_DW;

  logic          clk = 1'b0;
  logic          rst, flush, rx_valid, tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_ready, tx_valid, en_porta, wr_porta, full, empty;
  logic [DW-1:0] tx_data, wr_dataa, rd_dataa;
  logic [AW-1:0] addra;
  logic [AW:0]   level;

  int n_checks = 0;
  int n_fail   = 0;

  io_ram_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .en_porta (en_porta),
    .wr_porta (wr_porta),
    .addra    (addra),
    .wr_dataa (wr_dataa),
    .rd_dataa (rd_dataa),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) begin
    if (en_porta) begin
      if (wr_porta) mem[addra] <= wr_dataa;
      else          rd_dataa   <= mem[addra];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_flush(input string tag);
    cyc();
    flush = 1'b1; rx_valid = 1'b0;
    settle();
    chk({tag, "_en"}, 32'(en_porta), 32'd0);
    chk({tag, "_rxrdy"}, 32'(rx_ready), 32'd0);
    cyc();
    flush = 1'b0;
    settle();
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  task automatic wait_tx(input logic [DW-1:0] e, input string tag);
    int k;
    k = 0;
    while (!tx_valid && k < 20) begin
      cyc(); settle(); k++;
    end
    chk({tag, "_seen"}, 32'(tx_valid), 32'd1);
    chk(tag, 32'(tx_data), 32'(e));
    cyc(); settle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cyc_n, sent, got, bad, illegal;
    logic [AW-1:0] last_fill, last_rd, last_wr;
    bit seen_rd, seen_wr, rd_wrap, wr_wrap;
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_b;

    rst = 1'b1; flush = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    chk("rst_en", 32'(en_porta), 32'd0);
    rst = 1'b0;

    // Three writes; first read slips in right after the first write
    cyc(); rx_valid = 1'b1; rx_data = 8'h41; settle();
    chk("c0_rdy", 32'(rx_ready), 32'd1);
    chk("c0_wr", 32'(wr_porta), 32'd1);
    chk("c0_addr", 32'(addra), 32'd0);
    chk("c0_wdata", 32'(wr_dataa), 32'h41);
    cyc(); rx_data = 8'h42; settle();
    chk("c1_level", 32'(level), 32'd1);
    chk("c1_rdy", 32'(rx_ready), 32'd0);
    chk("c1_en", 32'(en_porta), 32'd1);
    chk("c1_wr", 32'(wr_porta), 32'd0);
    chk("c1_addr", 32'(addra), 32'd0);
    cyc(); settle();
    chk("c2_wr", 32'(wr_porta), 32'd1);
    chk("c2_addr", 32'(addra), 32'd1);
    chk("c2_txv", 32'(tx_valid), 32'd0);
    cyc(); rx_data = 8'h43; settle();
    chk("c3_txv", 32'(tx_valid), 32'd1);
    chk("c3_txd", 32'(tx_data), 32'h41);
    chk("c3_addr", 32'(addra), 32'd2);
    chk("c3_wr", 32'(wr_porta), 32'd1);
    cyc(); rx_valid = 1'b0; tx_ready = 1'b1; settle();
    chk("c4_level", 32'(level), 32'd2);
    chk("c4_en", 32'(en_porta), 32'd0);

    // Contention: tie-break alternates between RX and TX
    cyc(); rx_valid = 1'b1; rx_data = 8'h44; tx_ready = 1'b0; settle();
    chk("c5_rdy", 32'(rx_ready), 32'd0);
    chk("c5_wr", 32'(wr_porta), 32'd0);
    chk("c5_addr", 32'(addra), 32'd1);
    cyc(); rx_valid = 1'b0; settle();
    chk("c6_en", 32'(en_porta), 32'd0);
    cyc(); tx_ready = 1'b1; settle();
    chk("c7_txd", 32'(tx_data), 32'h42);
    chk("c7_level", 32'(level), 32'd1);
    cyc(); tx_ready = 1'b0; rx_valid = 1'b1; rx_data = 8'h44; settle();
    chk("c8_rdy", 32'(rx_ready), 32'd1);
    chk("c8_wr", 32'(wr_porta), 32'd1);
    chk("c8_addr", 32'(addra), 32'd3);
    cyc(); rx_data = 8'h45; settle();
    chk("c9_rdy", 32'(rx_ready), 32'd0);
    chk("c9_en", 32'(en_porta), 32'd1);
    chk("c9_wr", 32'(wr_porta), 32'd0);
    chk("c9_addr", 32'(addra), 32'd2);
    cyc(); settle();
    chk("c10_wr", 32'(wr_porta), 32'd1);
    chk("c10_addr", 32'(addra), 32'd4);
    cyc(); rx_valid = 1'b0; tx_ready = 1'b1; settle();
    chk("c11_txd", 32'(tx_data), 32'h43);
    chk("c11_level", 32'(level), 32'd2);
    cyc(); settle();
    wait_tx(8'h44, "drain44");
    wait_tx(8'h45, "drain45");
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_txv", 32'(tx_valid), 32'd0);

    // Fill to full with one byte parked in tx_data
    do_flush("fl1");
    tx_ready = 1'b0; cnt = 0; cyc_n = 0; last_fill = '1;
    while (cnt < 4097 && cyc_n < 10000) begin
      cyc(); cyc_n++;
      rx_valid = 1'b1; rx_data = 8'(cnt);
      settle();
      if (rx_ready) begin
        last_fill = addra;
        cnt++;
      end
    end
    chk("fill_count", 32'(cnt), 32'd4097);
    chk("fill_last_addr", 32'(last_fill), 32'd0);
    cyc(); rx_data = 8'hEE; settle();
    chk("full_flag", 32'(full), 32'd1);
    chk("full_level", 32'(level), 32'd4096);
    chk("full_rdy", 32'(rx_ready), 32'd0);
    chk("full_en", 32'(en_porta), 32'd0);
    chk("full_txd", 32'(tx_data), 32'h00);
    cyc(); rx_valid = 1'b0; tx_ready = 1'b1; settle();
    chk("full_txv", 32'(tx_valid), 32'd1);
    cyc(); tx_ready = 1'b0; settle();
    chk("full_rd_en", 32'(en_porta), 32'd1);
    chk("full_rd_wr", 32'(wr_porta), 32'd0);
    chk("full_rd_addr", 32'(addra), 32'd1);
    cyc(); rx_valid = 1'b1; rx_data = 8'hAA; settle();
    chk("after_rd_level", 32'(level), 32'd4095);
    chk("after_rd_rdy", 32'(rx_ready), 32'd1);
    chk("after_rd_wr_addr", 32'(addra), 32'd1);
    cyc(); rx_valid = 1'b0; settle();
    chk("after_rd_txd", 32'(tx_data), 32'h01);
    chk("after_rd_full", 32'(level), 32'd4096);

    // Streaming with both pointers wrapping
    do_flush("fl2");
    tx_ready = 1'b1; sent = 0; got = 0; bad = 0; illegal = 0; cyc_n = 0;
    seen_rd = 0; seen_wr = 0; rd_wrap = 0; wr_wrap = 0; last_rd = '0; last_wr = '0;
    while (got < 5000 && cyc_n < 40000) begin
      cyc(); cyc_n++;
      rx_valid = (sent < 5000);
      rx_data  = 8'(sent * 7 + 3);
      settle();
      if (en_porta) begin
        if (wr_porta) begin
          if (full) illegal++;
          if (seen_wr && last_wr == 12'hFFF && addra == 12'h000) wr_wrap = 1;
          last_wr = addra; seen_wr = 1;
        end else begin
          if (empty) illegal++;
          if (seen_rd && last_rd == 12'hFFF && addra == 12'h000) rd_wrap = 1;
          last_rd = addra; seen_rd = 1;
        end
      end
      if (rx_valid && rx_ready) begin
        q.push_back(rx_data);
        sent++;
      end
      if (tx_valid && tx_ready) begin
        if (q.size() == 0) bad++;
        else begin
          exp_b = q.pop_front();
          if (tx_data !== exp_b) bad++;
        end
        got++;
      end
    end
    chk("stream_got", 32'(got), 32'd5000);
    chk("stream_order_errs", 32'(bad), 32'd0);
    chk("stream_illegal", 32'(illegal), 32'd0);
    chk("stream_wr_wrap", 32'(wr_wrap), 32'd1);
    chk("stream_rd_wrap", 32'(rd_wrap), 32'd1);
    cyc(); rx_valid = 1'b0; settle();
    chk("stream_empty", 32'(empty), 32'd1);
    chk("stream_txv", 32'(tx_valid), 32'd0);

    // Flush while a read is in flight
    do_flush("fl3");
    tx_ready = 1'b0;
    cyc(); rx_valid = 1'b1; rx_data = 8'h77; settle();
    chk("fi_wr_addr", 32'(addra), 32'd0);
    cyc(); rx_valid = 1'b0; settle();
    chk("fi_rd_en", 32'(en_porta), 32'd1);
    chk("fi_rd_wr", 32'(wr_porta), 32'd0);
    cyc(); flush = 1'b1; settle();
    chk("fi_flush_en", 32'(en_porta), 32'd0);
    chk("fi_flush_rdy", 32'(rx_ready), 32'd0);
    cyc(); flush = 1'b0; settle();
    chk("fi_txv", 32'(tx_valid), 32'd0);
    chk("fi_level", 32'(level), 32'd0);
    chk("fi_empty", 32'(empty), 32'd1);
    cyc(); rx_valid = 1'b1; rx_data = 8'h88; settle();
    chk("fi_txv2", 32'(tx_valid), 32'd0);
    chk("fi_next_addr", 32'(addra), 32'd0);
    chk("fi_next_wr", 32'(wr_porta), 32'd1);
    cyc(); rx_valid = 1'b0; settle();
    chk("fi_level1", 32'(level), 32'd1);

    // Reset together with flush mid-operation
    cyc(); rst = 1'b1; flush = 1'b1; settle();
    chk("rst_mid_en", 32'(en_porta), 32'd0);
    cyc(); rst = 1'b0; flush = 1'b0; settle();
    chk("rst_mid_level", 32'(level), 32'd0);
    chk("rst_mid_txv", 32'(tx_valid), 32'd0);
    chk("rst_mid_txd", 32'(tx_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
